// File: rtl/tcm_rx_pkg.sv
// Shared definitions for the TCM receiver frame-lock controller.
//   WORD_W       : width of one aligned word from the bit aligner
//   SYNC_WORDS   : number of words in the frame sync sequence
//   SYNC_PATTERN : sync sequence packed oldest word in the MSBs
//                  (3FF,000,3FF,000,3FF,3FF)
//   lock_state_t : lock FSM encoding, also exported on the state port
package tcm_rx_pkg;

    localparam int WORD_W     = 10;
    localparam int SYNC_WORDS = 6;

    localparam logic [SYNC_WORDS*WORD_W-1:0] SYNC_PATTERN = 60'hFFC00FFC00FFFFF;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        VERIFY  = 2'd1,
        LOCKED  = 2'd2,
        REALIGN = 2'd3
    } lock_state_t;

endpackage

// File: rtl/tcm_receiver_lock_ctrl_if.sv
// Word stream interface between the bit aligner side and the lock controller.
//   wdat        : aligned word into the controller
//   dout        : word stream out, one cycle behind wdat
//   dout_valid  : dout qualifies as frame-locked data
//   frame_start : one-cycle strobe on an on-schedule sync while locked
// Modports: master = stream source / sink of dout, slave = lock controller.
interface tcm_receiver_lock_ctrl_if
    import tcm_rx_pkg::*;
    ();

    logic [WORD_W-1:0] wdat;
    logic [WORD_W-1:0] dout;
    logic              dout_valid;
    logic              frame_start;

    modport master (
        output wdat,
        input  dout,
        input  dout_valid,
        input  frame_start
    );

    modport slave (
        input  wdat,
        output dout,
        output dout_valid,
        output frame_start
    );

endinterface

// File: rtl/tcm_rx_sync_detect.sv
// Sync sequence detector: a SYNC_WORDS-deep shift window over the word
// stream plus a registered match flag.
//   clk, reset : word clock, synchronous active-high reset
//   clear      : empties the window and suppresses the hit flag
//   wdat       : incoming aligned word
//   sync_hit   : high for one cycle once the last sync word has been taken
//                into the window (same cycle dout shows that word)
module tcm_rx_sync_detect
    import tcm_rx_pkg::*;
    (
        input  logic              clk,
        input  logic              reset,
        input  logic              clear,
        input  logic [WORD_W-1:0] wdat,
        output logic              sync_hit
    );

    localparam int WIN_W = SYNC_WORDS * WORD_W;

    logic [WIN_W-1:0]      window_reg;
    logic [WIN_W-1:0]      window_next;
    logic [SYNC_WORDS-1:0] word_match;
    logic                  hit_reg;

    // Newest word enters at the LSB end so the packed window lines up with
    // SYNC_PATTERN (oldest word in the MSBs).
    assign window_next = {window_reg[WIN_W-WORD_W-1:0], wdat};

    // Compare against the window as it will be after this edge, so the hit
    // flag is registered together with the final sync word.
    generate
        for (genvar gi = 0; gi < SYNC_WORDS; gi++) begin : g_match
            assign word_match[gi] =
                (window_next[gi*WORD_W +: WORD_W] == SYNC_PATTERN[gi*WORD_W +: WORD_W]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            window_reg <= '0;
            hit_reg    <= 1'b0;
        end else begin
            window_reg <= window_next;
            hit_reg    <= &word_match;
        end
    end

    assign sync_hit = hit_reg & ~clear;

endmodule

// File: rtl/tcm_receiver_lock_ctrl.sv
// Frame-lock controller behind the TCM receiver bit aligner. Finds the
// 6-word sync sequence, verifies it recurs every FRAME_LEN words, holds
// lock while it keeps arriving on schedule, and asks the aligner to
// realign when hunting runs too long.
//   clk, reset    : word clock, synchronous active-high reset
//   bus (slave)   : wdat in; dout, dout_valid, frame_start out
//   align_rst     : reset request to the bit aligner
//   locked        : frame lock achieved
//   state         : 0=HUNT 1=VERIFY 2=LOCKED 3=REALIGN
//   sync_err_cnt  : missed syncs while locked, saturating, cleared by reset
module tcm_receiver_lock_ctrl
    import tcm_rx_pkg::*;
    #(
        parameter int FRAME_LEN    = 1024,
        parameter int LOCK_CNT     = 3,
        parameter int UNLOCK_CNT   = 4,
        parameter int HUNT_TIMEOUT = 4096,
        parameter int RST_LEN      = 4,
        parameter int FLUSH_LEN    = 8
    )
    (
        input  logic                      clk,
        input  logic                      reset,
        tcm_receiver_lock_ctrl_if.slave   bus,
        output logic                      align_rst,
        output logic                      locked,
        output logic [1:0]                state,
        output logic [15:0]               sync_err_cnt
    );

    localparam int WC_W = $clog2(FRAME_LEN);
    localparam int HC_W = $clog2(HUNT_TIMEOUT + 1);
    localparam int RC_W = $clog2(RST_LEN + FLUSH_LEN + 1);

    localparam logic [WC_W-1:0] WC_LAST  = WC_W'(FRAME_LEN - 1);
    localparam logic [HC_W-1:0] HC_LAST  = HC_W'(HUNT_TIMEOUT - 1);
    localparam logic [RC_W-1:0] RC_RST   = RC_W'(RST_LEN);
    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RST_LEN + FLUSH_LEN - 1);
    localparam logic [3:0]      LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0]      UNLOCK_N = 4'(UNLOCK_CNT);

    lock_state_t       state_reg,    state_next;
    logic [WC_W-1:0]   word_cnt_reg, word_cnt_next;
    logic [HC_W-1:0]   hunt_cnt_reg, hunt_cnt_next;
    logic [RC_W-1:0]   rl_cnt_reg,   rl_cnt_next;
    logic [3:0]        good_cnt_reg, good_cnt_next;
    logic [3:0]        miss_cnt_reg, miss_cnt_next;
    logic [15:0]       err_cnt_reg,  err_cnt_next;
    logic [WORD_W-1:0] dout_reg;

    logic sync_hit;
    logic expected;

    tcm_rx_sync_detect u_sync_detect (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_reg == REALIGN),
        .wdat     (bus.wdat),
        .sync_hit (sync_hit)
    );

    // A sync is due whenever the frame counter wraps back to zero.
    assign expected = (word_cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= HUNT;
            word_cnt_reg <= '0;
            hunt_cnt_reg <= '0;
            rl_cnt_reg   <= '0;
            good_cnt_reg <= '0;
            miss_cnt_reg <= '0;
            err_cnt_reg  <= '0;
            dout_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            word_cnt_reg <= word_cnt_next;
            hunt_cnt_reg <= hunt_cnt_next;
            rl_cnt_reg   <= rl_cnt_next;
            good_cnt_reg <= good_cnt_next;
            miss_cnt_reg <= miss_cnt_next;
            err_cnt_reg  <= err_cnt_next;
            dout_reg     <= bus.wdat;
        end
    end

    always_comb begin
        state_next    = state_reg;
        word_cnt_next = (word_cnt_reg == WC_LAST) ? '0 : word_cnt_reg + 1'b1;
        hunt_cnt_next = hunt_cnt_reg;
        rl_cnt_next   = rl_cnt_reg;
        good_cnt_next = good_cnt_reg;
        miss_cnt_next = miss_cnt_reg;
        err_cnt_next  = err_cnt_reg;

        case (state_reg)
            HUNT: begin
                if (sync_hit) begin
                    // Anchor the frame: the hit cycle is word 0, so the
                    // counter reads 0 again exactly FRAME_LEN cycles later.
                    word_cnt_next = WC_W'(1);
                    hunt_cnt_next = '0;
                    good_cnt_next = 4'd1;
                    miss_cnt_next = '0;
                    state_next    = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
                end else if (hunt_cnt_reg == HC_LAST) begin
                    hunt_cnt_next = '0;
                    rl_cnt_next   = '0;
                    state_next    = REALIGN;
                end else begin
                    hunt_cnt_next = hunt_cnt_reg + 1'b1;
                end
            end

            VERIFY: begin
                if (expected) begin
                    if (sync_hit) begin
                        if (good_cnt_reg + 4'd1 == LOCK_N) begin
                            miss_cnt_next = '0;
                            state_next    = LOCKED;
                        end else begin
                            good_cnt_next = good_cnt_reg + 4'd1;
                        end
                    end else begin
                        hunt_cnt_next = '0;
                        state_next    = HUNT;
                    end
                end
            end

            LOCKED: begin
                if (expected) begin
                    if (sync_hit) begin
                        miss_cnt_next = '0;
                    end else begin
                        if (err_cnt_reg != 16'hFFFF) begin
                            err_cnt_next = err_cnt_reg + 16'd1;
                        end
                        if (miss_cnt_reg + 4'd1 == UNLOCK_N) begin
                            miss_cnt_next = '0;
                            hunt_cnt_next = '0;
                            state_next    = HUNT;
                        end else begin
                            miss_cnt_next = miss_cnt_reg + 4'd1;
                        end
                    end
                end
            end

            REALIGN: begin
                // First RST_LEN cycles drive align_rst, the rest let the
                // aligner settle before hunting resumes on a clean window.
                if (rl_cnt_reg == RC_LAST) begin
                    rl_cnt_next   = '0;
                    hunt_cnt_next = '0;
                    state_next    = HUNT;
                end else begin
                    rl_cnt_next = rl_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = HUNT;
            end
        endcase
    end

    // Outputs decode registered state only, so reset clears them on the
    // very next edge.
    assign align_rst       = (state_reg == REALIGN) && (rl_cnt_reg < RC_RST);
    assign locked          = (state_reg == LOCKED);
    assign state           = state_reg;
    assign sync_err_cnt    = err_cnt_reg;
    assign bus.dout        = dout_reg;
    assign bus.dout_valid  = locked;
    assign bus.frame_start = locked && expected && sync_hit;

endmodule
